// File: rtl/sobel_pkg.sv
// Shared Sobel pipeline helpers: pad width, padded row width,
// column counter width, legal kernel check and column FSM codes.
package sobel_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LEFT   = 2'd1;
  localparam logic [1:0] ST_CENTRE = 2'd2;
  localparam logic [1:0] ST_RIGHT  = 2'd3;

  function automatic int pad_of(input int ksz);
    return (ksz - 1) / 2;
  endfunction

  function automatic int out_w(input int iw, input int ksz);
    return iw + ksz - 1;
  endfunction

  function automatic int col_w(input int iw, input int ksz);
    return $clog2(iw + ksz);
  endfunction

  function automatic bit ksz_ok(input int ksz);
    return (ksz == 3) || (ksz == 5) || (ksz == 7);
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Enabled shift register of DEPTH pixels; q is the oldest stage.
// Ports: clk, rst (sync, high), en (shift), d (pixel in), q (pixel out).
module pix_delay_line #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DEPTH-1:0][DW-1:0] sr_q;
  logic [DEPTH-1:0][DW-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/bound_left_right_add.sv
// Left/right edge-replicate padding of each row ahead of the window generator.
// Ports: clk, rst, din_vsync/hsync/din in; dout_vsync/hsync/dout, fmt_err out.
module bound_left_right_add
  import sobel_pkg::*;
#(
  parameter int KSZ = 3,
  parameter int DW  = 8,
  parameter int IW  = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vsync,
  input  logic          din_hsync,
  input  logic [DW-1:0] din,
  output logic          dout_vsync,
  output logic          dout_hsync,
  output logic [DW-1:0] dout,
  output logic          fmt_err
);

  localparam int PAD = pad_of(KSZ);
  localparam int OW  = out_w(IW, KSZ);
  localparam int CW  = col_w(IW, KSZ);

  localparam logic [CW-1:0] PAD_C  = CW'(PAD);
  localparam logic [CW-1:0] CEN_C  = CW'(PAD + IW);
  localparam logic [CW-1:0] LAST_C = CW'(OW - 1);
  localparam logic [CW-1:0] IW_C   = CW'(IW);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  if (!ksz_ok(KSZ)) begin : g_bad_ksz
    $error("KSZ must be 3, 5 or 7");
  end

  logic          vs_q, vs_d;
  logic          hs_q, hs_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] rx_q, rx_d;
  logic          in_act_q, in_act_d;
  logic [DW-1:0] p0_q, p0_d;
  logic [DW-1:0] last_q, last_d;
  logic          err_q, err_d;

  logic          vs_rise;
  logic          hs_rise;
  logic          row_act;
  logic          in_live;
  logic          accept;
  logic          dl_en;
  logic [DW-1:0] dl_q;
  logic [CW-1:0] col_nxt;
  logic [CW-1:0] src_idx;

  // Centre columns read the pixel that arrived PAD+1 clocks earlier.
  pix_delay_line #(
    .DEPTH(PAD + 1),
    .DW   (DW)
  ) u_dl (
    .clk(clk),
    .rst(rst),
    .en (dl_en),
    .d  (din),
    .q  (dl_q)
  );

  always_comb begin
    vs_rise = din_vsync & ~vs_q;
    hs_rise = din_hsync & ~hs_q;
    // A frame start wipes any row in flight before a new row is looked at.
    row_act = (state_q != ST_IDLE) & ~vs_rise;
    in_live = in_act_q & ~vs_rise;
    accept  = hs_rise
            | (in_live & din_hsync & (rx_q < IW_C));
    dl_en   = hs_rise | (state_q != ST_IDLE);
    col_nxt = col_q + ONE_C;
  end

  always_comb begin
    vs_d     = din_vsync;
    hs_d     = din_hsync;
    state_d  = state_q;
    col_d    = col_q;
    rx_d     = rx_q;
    in_act_d = in_act_q;
    p0_d     = p0_q;
    last_d   = last_q;
    err_d    = err_q;

    if (vs_rise) begin
      state_d  = ST_IDLE;
      col_d    = '0;
      in_act_d = 1'b0;
      err_d    = 1'b0;
    end else if (row_act) begin
      if (col_q == LAST_C) begin
        state_d = ST_IDLE;
        col_d   = '0;
      end else begin
        col_d = col_nxt;
        if (col_nxt < PAD_C) begin
          state_d = ST_LEFT;
        end else if (col_nxt < CEN_C) begin
          state_d = ST_CENTRE;
        end else begin
          state_d = ST_RIGHT;
        end
      end
    end

    if (hs_rise) begin
      state_d  = ST_LEFT;
      col_d    = '0;
      in_act_d = 1'b1;
      rx_d     = ONE_C;
      p0_d     = din;
      last_d   = din;
      // New row while the previous padded row is still going out.
      if (row_act) begin
        err_d = 1'b1;
      end
    end else begin
      if (accept) begin
        rx_d   = rx_q + ONE_C;
        last_d = din;
      end
      // Long row: extra pixels are dropped.
      if (in_live & din_hsync & ~accept) begin
        err_d = 1'b1;
      end
      // Short row: hsync fell before IW pixels.
      if (in_live & ~din_hsync) begin
        in_act_d = 1'b0;
        if (rx_q < IW_C) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      state_q  <= ST_IDLE;
      col_q    <= '0;
      rx_q     <= '0;
      in_act_q <= 1'b0;
      p0_q     <= '0;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      state_q  <= state_d;
      col_q    <= col_d;
      rx_q     <= rx_d;
      in_act_q <= in_act_d;
      p0_q     <= p0_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    src_idx = col_q - PAD_C;
    dout    = '0;
    unique case (1'b1)
      (state_q == ST_LEFT): begin
        dout = p0_q;
      end
      (state_q == ST_CENTRE): begin
        // Past the end of a short row, hold the last real pixel.
        dout = (src_idx < rx_q) ? dl_q : last_q;
      end
      (state_q == ST_RIGHT): begin
        dout = last_q;
      end
      default: begin
        dout = '0;
      end
    endcase
  end

  assign dout_hsync = (state_q != ST_IDLE);
  assign dout_vsync = vs_q;
  assign fmt_err    = err_q;

endmodule
